// File: rtl/fir_pkg.sv
// Shared types and constants for the fir load/stream driver.
package fir_pkg;

  // Driver sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_COEF   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam int NTAPS_DEF = 5;
  localparam int DW_DEF    = 8;

  // Tap counter must be able to hold the value NTAPS itself
  function automatic int tap_cnt_width(input int ntaps);
    return $clog2(ntaps + 1);
  endfunction

endpackage

// File: rtl/fir_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fir_sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear, or increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fir_driver.sv
// Initiator-side sequencer for the fir load/stream interface. Accepts
// coefficient and sample words over valid/ready, drives the fir with a
// guaranteed idle cycle between mode changes, and tracks fault/result status.
module fir_driver
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NTAPS = NTAPS_DEF,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  output logic          coef_ready,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          smp_ready,
  output logic [DW-1:0] data_in,
  output logic          coef_enable,
  output logic          sample_enable,
  input  logic          fir_error,
  input  logic          fir_out_enable,
  output logic          coef_loaded,
  output logic          err_flag,
  input  logic          err_clr,
  output logic [CW-1:0] out_count
);

  localparam int TCW = tap_cnt_width(NTAPS);
  localparam logic [TCW-1:0] LAST_TAP = TCW'(NTAPS - 1);

  state_e         state_q, state_d;
  state_e         target_q, target_d;
  logic [TCW-1:0] tap_cnt_q, tap_cnt_d;
  logic [DW-1:0]  data_in_q, data_in_d;
  logic           coef_en_q, coef_en_d;
  logic           smp_en_q, smp_en_d;
  logic           coef_loaded_q, coef_loaded_d;
  logic           err_flag_q, err_flag_d;
  logic           cnt_clr;

  // Readies are a pure function of state; coefficients pre-empt samples
  assign coef_ready = (state_q == ST_COEF);
  assign smp_ready  = (state_q == ST_STREAM) && !coef_valid;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    tap_cnt_d     = tap_cnt_q;
    data_in_d     = data_in_q;
    coef_en_d     = 1'b0;
    smp_en_d      = 1'b0;
    coef_loaded_d = coef_loaded_q;
    err_flag_d    = err_flag_q;
    cnt_clr       = 1'b0;

    if (fir_error && (state_q != ST_FAULT)) begin
      // Any word accepted this cycle is dropped: enables stay low, data holds
      state_d       = ST_FAULT;
      err_flag_d    = 1'b1;
      coef_loaded_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (coef_valid) begin
            state_d  = ST_GAP;
            target_d = ST_COEF;
          end else if (smp_valid && coef_loaded_q) begin
            state_d  = ST_GAP;
            target_d = ST_STREAM;
          end
        end
        ST_GAP: begin
          state_d = target_q;
          if (target_q == ST_COEF) begin
            tap_cnt_d     = '0;
            coef_loaded_d = 1'b0;
            cnt_clr       = 1'b1;
          end
        end
        ST_COEF: begin
          if (coef_valid) begin
            data_in_d = coef_data;
            coef_en_d = 1'b1;
            tap_cnt_d = tap_cnt_q + TCW'(1);
            if (tap_cnt_q == LAST_TAP) begin
              coef_loaded_d = 1'b1;
              tap_cnt_d     = '0;
              if (smp_valid) begin
                state_d  = ST_GAP;
                target_d = ST_STREAM;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_STREAM: begin
          if (coef_valid) begin
            state_d  = ST_GAP;
            target_d = ST_COEF;
          end else if (smp_valid) begin
            data_in_d = smp_data;
            smp_en_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (err_clr) begin
            state_d       = ST_IDLE;
            err_flag_d    = 1'b0;
            coef_loaded_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      target_q      <= ST_IDLE;
      tap_cnt_q     <= '0;
      data_in_q     <= '0;
      coef_en_q     <= 1'b0;
      smp_en_q      <= 1'b0;
      coef_loaded_q <= 1'b0;
      err_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      tap_cnt_q     <= tap_cnt_d;
      data_in_q     <= data_in_d;
      coef_en_q     <= coef_en_d;
      smp_en_q      <= smp_en_d;
      coef_loaded_q <= coef_loaded_d;
      err_flag_q    <= err_flag_d;
    end
  end

  fir_sat_counter #(.CW(CW)) u_out_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (fir_out_enable),
    .count (out_count)
  );

  assign data_in       = data_in_q;
  assign coef_enable   = coef_en_q;
  assign sample_enable = smp_en_q;
  assign coef_loaded   = coef_loaded_q;
  assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_fir_driver.sv
// Scoreboard bench for fir_driver: every accepted word is queued with its
// handshake cycle and must reappear on data_in with the right enable one
// cycle later; mode-separation and fault/status behaviour checked directly.
module tb_fir_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        coef_valid = 1'b0;
  logic [7:0]  coef_data = '0;
  logic        coef_ready;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_data = '0;
  logic        smp_ready;
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic        fir_error = 1'b0;
  logic        fir_out_enable = 1'b0;
  logic        coef_loaded;
  logic        err_flag;
  logic        err_clr = 1'b0;
  logic [15:0] out_count;

  typedef struct {
    logic       is_coef;
    logic [7:0] data;
    int         cyc;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_coef_out = 0;
  int n_smp_out  = 0;
  logic prev_coef_en = 1'b0;
  logic prev_smp_en  = 1'b0;

  fir_driver #(.DW(8), .NTAPS(5), .CW(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .coef_valid     (coef_valid),
    .coef_data      (coef_data),
    .coef_ready     (coef_ready),
    .smp_valid      (smp_valid),
    .smp_data       (smp_data),
    .smp_ready      (smp_ready),
    .data_in        (data_in),
    .coef_enable    (coef_enable),
    .sample_enable  (sample_enable),
    .fir_error      (fir_error),
    .fir_out_enable (fir_out_enable),
    .coef_loaded    (coef_loaded),
    .err_flag       (err_flag),
    .err_clr        (err_clr),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      prev_coef_en = 1'b0;
      prev_smp_en  = 1'b0;
    end else begin
      check_val("enables_exclusive", {31'd0, coef_enable && sample_enable}, 32'd0);
      check_val("gap_smp_to_coef", {31'd0, coef_enable && prev_smp_en}, 32'd0);
      check_val("gap_coef_to_smp", {31'd0, sample_enable && prev_coef_en}, 32'd0);
      if (sb_q.size() > 0 && sb_q[0].cyc + 1 == cyc) begin
        sb_item_t e;
        e = sb_q.pop_front();
        check_val("sb_enable", {30'd0, coef_enable, sample_enable},
                  e.is_coef ? 32'd2 : 32'd1);
        check_val("sb_data", {24'd0, data_in}, {24'd0, e.data});
        if (coef_enable && e.is_coef) n_coef_out++;
        if (sample_enable && !e.is_coef) n_smp_out++;
      end else if (coef_enable || sample_enable) begin
        check_val("sb_unexpected", {30'd0, coef_enable, sample_enable}, 32'd0);
      end
      // A word accepted while fir_error is high must be dropped
      if (!fir_error) begin
        if (coef_valid && coef_ready) sb_q.push_back('{1'b1, coef_data, cyc});
        if (smp_valid && smp_ready)   sb_q.push_back('{1'b0, smp_data, cyc});
      end
      prev_coef_en = coef_enable;
      prev_smp_en  = sample_enable;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_coef(input logic [7:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    coef_valid = 1'b1;
    coef_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coef_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    @(posedge clk);
    #1;
    if (!ok) check_val("coef_hs_timeout", {31'd0, coef_ready}, 32'd1);
  endtask

  task automatic push_smp(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    smp_valid = 1'b1;
    smp_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (smp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) check_val("smp_hs_timeout", {31'd0, smp_ready}, 32'd1);
  endtask

  // Full load; loaded flag must rise only after the last word
  task automatic load_set(input logic [7:0] base, input bit check_stall);
    int w;
    for (int k = 0; k < 5; k++) begin
      push_coef(base + 8'(k), w);
      if (check_stall && k > 0) check_val("coef_back_to_back", w, 32'd0);
      check_val("coef_loaded_progress", {31'd0, coef_loaded}, (k == 4) ? 32'd1 : 32'd0);
    end
    coef_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_val("rst_data_in", {24'd0, data_in}, 32'd0);
    check_val("rst_enables", {30'd0, coef_enable, sample_enable}, 32'd0);
    check_val("rst_readies", {30'd0, coef_ready, smp_ready}, 32'd0);
    check_val("rst_status", {30'd0, coef_loaded, err_flag}, 32'd0);
    check_val("rst_out_count", {16'd0, out_count}, 32'd0);
    step(2);
    reset = 1'b1;

    // Samples without coefficients are ignored
    smp_valid = 1'b1;
    smp_data  = 8'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("nocoef_smp_ready", {31'd0, smp_ready}, 32'd0);
    end
    smp_valid = 1'b0;
    step(2);
    check_val("nocoef_smp_out", n_smp_out, 32'd0);
    $display("txn: samples before load ignored");

    // Load 4..8
    n_coef_out = 0;
    load_set(8'd4, 1'b1);
    step(2);
    check_val("load1_count", n_coef_out, 32'd5);
    check_val("load1_loaded", {31'd0, coef_loaded}, 32'd1);
    $display("txn: coefficient load 4..8");

    // Stream 1,1 and count results
    n_smp_out = 0;
    push_smp(8'd1);
    push_smp(8'd1);
    smp_valid = 1'b0;
    fir_out_enable = 1'b1;
    step(3);
    fir_out_enable = 1'b0;
    step(1);
    check_val("stream1_count", n_smp_out, 32'd2);
    check_val("out_count_3", {16'd0, out_count}, 32'd3);
    check_val("stream1_idle_ready", {30'd0, coef_ready, smp_ready}, 32'd0);
    $display("txn: stream 1,1");

    // Coefficient pre-emption while streaming
    n_smp_out = 0;
    n_coef_out = 0;
    push_smp(8'd2);
    smp_data = 8'd1;
    push_smp(8'd1);
    coef_valid = 1'b1;
    coef_data  = 8'd10;
    @(negedge clk);
    check_val("preempt_smp_ready", {31'd0, smp_ready}, 32'd0);
    begin
      int w;
      push_coef(8'd10, w);
    end
    check_val("preempt_loaded_clr", {31'd0, coef_loaded}, 32'd0);
    check_val("preempt_out_count_clr", {16'd0, out_count}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      int w;
      push_coef(8'd10 + 8'(k), w);
      check_val("preempt_loaded", {31'd0, coef_loaded}, (k == 4) ? 32'd1 : 32'd0);
    end
    coef_valid = 1'b0;
    push_smp(8'd1);
    push_smp(8'd1);
    smp_valid = 1'b0;
    step(3);
    check_val("preempt_coef_count", n_coef_out, 32'd5);
    check_val("preempt_smp_count", n_smp_out, 32'd4);
    $display("txn: coefficient reload 10..14 during stream");

    // Fault during streaming
    push_smp(8'd5);
    smp_data  = 8'd6;
    fir_error = 1'b1;
    step(1);
    fir_error = 1'b0;
    check_val("fault_err_flag", {31'd0, err_flag}, 32'd1);
    check_val("fault_enables", {30'd0, coef_enable, sample_enable}, 32'd0);
    check_val("fault_readies", {30'd0, coef_ready, smp_ready}, 32'd0);
    step(2);
    check_val("fault_hold", {29'd0, err_flag, coef_enable, sample_enable}, 32'd4);
    smp_valid = 1'b0;
    err_clr   = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_val("clr_err_flag", {31'd0, err_flag}, 32'd0);
    check_val("clr_coef_loaded", {31'd0, coef_loaded}, 32'd0);
    smp_valid = 1'b1;
    smp_data  = 8'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("clr_idle_smp_ready", {31'd0, smp_ready}, 32'd0);
    end
    smp_valid = 1'b0;
    step(1);
    $display("txn: fault and clear");

    // Reset after the third coefficient
    begin
      int w;
      push_coef(8'd4, w);
      push_coef(8'd5, w);
      push_coef(8'd6, w);
    end
    reset = 1'b0;
    #1;
    check_val("midrst_data_in", {24'd0, data_in}, 32'd0);
    check_val("midrst_enables", {30'd0, coef_enable, sample_enable}, 32'd0);
    check_val("midrst_readies", {30'd0, coef_ready, smp_ready}, 32'd0);
    check_val("midrst_status", {30'd0, coef_loaded, err_flag}, 32'd0);
    coef_valid = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    n_coef_out = 0;
    load_set(8'd20, 1'b0);
    step(2);
    check_val("reload_count", n_coef_out, 32'd5);
    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("txn: reset mid-load then full reload");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_driver.md
Name: fir_driver

Overview:
- Initiator-side sequencer for the fir block's load/stream interface.
- Accepts coefficient and sample words from upstream over valid/ready streams.
- Drives the fir inputs data_in, coef_enable and sample_enable under the fir mode-switch rules.
- Watches the fir error and out_enable outputs, reports fault status, and counts results.

Parameters:
- DW, 8: width of coefficient, sample and data_in words.
- NTAPS, 5: coefficients per full load; must equal the fir tap count.
- CW, 16: width of the result counter out_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coef_valid  in  1  upstream coefficient word valid.
- coef_data  in  DW  upstream coefficient word.
- coef_ready  out  1  coefficient word accepted when valid and ready are both high.
- smp_valid  in  1  upstream sample valid.
- smp_data  in  DW  upstream sample.
- smp_ready  out  1  sample accepted when valid and ready are both high.
- data_in  out  DW  word to the fir.
- coef_enable  out  1  to the fir: data_in is a coefficient.
- sample_enable  out  1  to the fir: data_in is a sample.
- fir_error  in  1  error output of the fir.
- fir_out_enable  in  1  out_enable output of the fir.
- coef_loaded  out  1  a full set of NTAPS coefficients has been delivered since the last reset, clear or fault.
- err_flag  out  1  sticky fault indicator.
- err_clr  in  1  synchronous fault clear.
- out_count  out  CW  number of fir_out_enable cycles since the last load start; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including data_in, both enables, both readies, coef_loaded, err_flag and out_count.
- States:
  - IDLE: no mode active.
  - GAP: exactly one cycle with both enables low, inserted before every mode entry.
  - COEF: coefficient load in progress.
  - STREAM: sample streaming.
  - FAULT: fir error seen; waits for err_clr.
- Invariant: coef_enable and sample_enable are never high in the same cycle. Any change of fir mode is separated by at least one cycle with both low.
- Readies (combinational from state):
  - coef_ready = (state==COEF).
  - smp_ready = (state==STREAM) && !coef_valid.
- Output timing: data_in, coef_enable and sample_enable are registered. An accepted word appears on data_in with its enable exactly one cycle after the handshake. A cycle with no handshake drives both enables low in the next cycle. data_in holds its last value when idle.
- Transitions:
  - IDLE: coef_valid -> GAP (target COEF). smp_valid with coef_loaded=1 -> GAP (target STREAM). smp_valid with coef_loaded=0 is ignored; smp_ready stays 0.
  - GAP -> target state after one cycle.
  - COEF: tap counter (width clog2(NTAPS+1)) counts accepted words. On GAP->COEF entry, clear coef_loaded and out_count. Upstream bubbles are allowed; coef_enable is low in bubble cycles. After the NTAPSth accepted word: set coef_loaded, then go to GAP (target STREAM) if smp_valid, else IDLE.
  - STREAM: coef_valid has priority over samples. With coef_valid high, smp_ready=0 that cycle, then -> GAP (target COEF). Otherwise, if smp_valid is low -> IDLE.
- Faults: fir_error=1 in any non-FAULT state -> FAULT next cycle. err_flag is set, enables and readies are forced low, and any in-flight registered word is dropped. In FAULT: err_clr=1 -> IDLE with err_flag=0 and coef_loaded=0. err_clr outside FAULT has no effect.
- Result counter: out_count increments on each fir_out_enable=1 cycle in any state, and saturates.
- Reset asserted mid-load: immediate return to reset values. A partial coefficient set is never reported as loaded.

Decomposition:
- fir_pkg holds:
  - the state enum (IDLE, GAP, COEF, STREAM, FAULT);
  - default constants NTAPS_DEF=5 and DW_DEF=8;
  - a function computing the tap-counter width.
- No sub-module is required. The saturating result counter may be factored as fir_sat_counter if reuse is wanted.

Test Plan:
- Load 4,5,6,7,8 with coef_valid held high -> one GAP cycle, then coef_enable high for 5 consecutive cycles with data_in 4..8 (one cycle after each handshake), then coef_loaded=1.
- After that load, stream samples 1,1 -> one GAP cycle with both enables low, then sample_enable high for 2 cycles with data_in=1, then IDLE.
- While streaming 2,1,1,1, assert coef_valid with 10..14 -> smp_ready drops that cycle, both enables are low for one cycle, coef_enable carries 10..14, coef_loaded is 0 during the load and 1 after, and out_count is cleared.
- smp_valid=1 with data 3 straight after reset -> smp_ready stays 0, sample_enable never rises, state stays IDLE.
- Pulse fir_error during STREAM -> next cycle err_flag=1 and both enables and both readies are 0. err_clr -> IDLE with err_flag=0 and coef_loaded=0.
- Drive reset low after the 3rd coefficient -> all outputs 0 immediately. A subsequent full 5-word load sets coef_loaded only after the 5th word.
